// File: rtl/bus_arb_mux.sv
// Registered bus multiplexer with fixed-priority or round-robin arbitration and conflict reporting.
// Optional 8-bit saturating conflict counter is enabled by defining BUS_ARB_CONFLICT_CNT_EN.
module bus_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int MODE  = 0
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NSRC*WIDTH-1:0]     src_data,
  input  logic [NSRC-1:0]           drv_req,
  input  logic                      hold,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          bus_out,
  output logic                      bus_valid,
  output logic [NSRC-1:0]           grant,
  output logic [$clog2(NSRC)-1:0]   grant_idx,
  output logic                      conflict,
  output logic                      conflict_sticky
`ifdef BUS_ARB_CONFLICT_CNT_EN
  ,
  output logic [7:0]                conflict_cnt
`endif
);

  localparam int IW = $clog2(NSRC);

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    next_ptr;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             multi;

  // Round-robin searches from rr_ptr upward first; the plain lowest-index pass
  // then serves as the wrap-around for MODE=1 and as the whole search for MODE=0.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    if (MODE == 1) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!found && drv_req[i] && (IW'(i) >= rr_ptr)) begin
          found    = 1'b1;
          win_idx  = IW'(i);
          win_data = src_data[i*WIDTH +: WIDTH];
        end
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (!found && drv_req[i]) begin
        found    = 1'b1;
        win_idx  = IW'(i);
        win_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign multi    = |(drv_req & (drv_req - NSRC'(1)));
  assign next_ptr = (win_idx == IW'(NSRC - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      bus_out         <= '0;
      bus_valid       <= 1'b0;
      grant           <= '0;
      grant_idx       <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      rr_ptr          <= '0;
    end else begin
      if (!hold) begin
        bus_out   <= found ? win_data : '0;
        bus_valid <= found;
        grant     <= found ? (NSRC'(1) << win_idx) : '0;
        grant_idx <= found ? win_idx : '0;
        conflict  <= multi;
        if (found)
          rr_ptr <= next_ptr;
      end else begin
        conflict <= 1'b0;
      end
      // A conflict seen in the same cycle as err_clr keeps the flag set.
      if (!hold && multi)
        conflict_sticky <= 1'b1;
      else if (err_clr)
        conflict_sticky <= 1'b0;
    end
  end

`ifdef BUS_ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (clr)
      conflict_cnt <= '0;
    else if (!hold && multi)
      conflict_cnt <= err_clr ? 8'd1 : ((conflict_cnt == 8'd255) ? 8'd255 : conflict_cnt + 8'd1);
    else if (err_clr)
      conflict_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_bus_arb_mux.sv
// Randomized self-checking bench for bus_arb_mux: fixed-priority and round-robin
// instances share stimulus and are compared against a search-based reference model.
module tb_bus_arb_mux;

  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int IW    = $clog2(NSRC);

  logic                  clk = 1'b0;
  logic                  clr;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       drv_req;
  logic                  hold;
  logic                  err_clr;

  logic [WIDTH-1:0] bus_out   [2];
  logic             bus_valid [2];
  logic [NSRC-1:0]  grant     [2];
  logic [IW-1:0]    grant_idx [2];
  logic             conflict  [2];
  logic             sticky    [2];
`ifdef BUS_ARB_CONFLICT_CNT_EN
  logic [7:0]       cnt       [2];
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [WIDTH-1:0] exp_bus   [2];
  int               exp_valid [2];
  int               exp_grant [2];
  int               exp_idx   [2];
  int               ptr       [2];
  int               exp_conflict;
  int               exp_sticky;
  int               exp_cnt;

  always #5 clk = ~clk;

  bus_arb_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .MODE(0)) dut_fixed (
    .clk(clk), .clr(clr), .src_data(src_data), .drv_req(drv_req), .hold(hold), .err_clr(err_clr),
    .bus_out(bus_out[0]), .bus_valid(bus_valid[0]), .grant(grant[0]), .grant_idx(grant_idx[0]),
    .conflict(conflict[0]), .conflict_sticky(sticky[0])
`ifdef BUS_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(cnt[0])
`endif
  );

  bus_arb_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .MODE(1)) dut_rr (
    .clk(clk), .clr(clr), .src_data(src_data), .drv_req(drv_req), .hold(hold), .err_clr(err_clr),
    .bus_out(bus_out[1]), .bus_valid(bus_valid[1]), .grant(grant[1]), .grant_idx(grant_idx[1]),
    .conflict(conflict[1]), .conflict_sticky(sticky[1])
`ifdef BUS_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(cnt[1])
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requesting source found walking upward from start, wrapping; -1 if none.
  function automatic int findWinner(input logic [NSRC-1:0] req, input int start);
    for (int k = 0; k < NSRC; k++) begin
      int s;
      s = (start + k) % NSRC;
      if (req[s]) return s;
    end
    return -1;
  endfunction

  task automatic modelStep();
    int nreq;
    int w;
    if (clr) begin
      for (int m = 0; m < 2; m++) begin
        exp_bus[m] = '0; exp_valid[m] = 0; exp_grant[m] = 0; exp_idx[m] = 0; ptr[m] = 0;
      end
      exp_conflict = 0; exp_sticky = 0; exp_cnt = 0;
      return;
    end
    nreq = $countones(drv_req);
    if (!hold) begin
      for (int m = 0; m < 2; m++) begin
        w = findWinner(drv_req, (m == 0) ? 0 : ptr[m]);
        if (w < 0) begin
          exp_bus[m] = '0; exp_valid[m] = 0; exp_grant[m] = 0; exp_idx[m] = 0;
        end else begin
          exp_bus[m] = src_data[w*WIDTH +: WIDTH];
          exp_valid[m] = 1; exp_grant[m] = 1 << w; exp_idx[m] = w;
          ptr[m] = (w + 1) % NSRC;
        end
      end
      exp_conflict = (nreq > 1) ? 1 : 0;
    end else begin
      exp_conflict = 0;
    end
    if (!hold && nreq > 1) begin
      exp_sticky = 1;
      exp_cnt = err_clr ? 1 : ((exp_cnt + 1 > 255) ? 255 : exp_cnt + 1);
    end else if (err_clr) begin
      exp_sticky = 0;
      exp_cnt = 0;
    end
  endtask

  task automatic compareAll();
    for (int m = 0; m < 2; m++) begin
      string p;
      p = (m == 0) ? "fixed" : "rr";
      checkOutput({p, ".bus_out"},   64'(bus_out[m]),   64'(exp_bus[m]));
      checkOutput({p, ".bus_valid"}, 64'(bus_valid[m]), 64'(exp_valid[m]));
      checkOutput({p, ".grant"},     64'(grant[m]),     64'(exp_grant[m]));
      checkOutput({p, ".grant_idx"}, 64'(grant_idx[m]), 64'(exp_idx[m]));
      checkOutput({p, ".conflict"},  64'(conflict[m]),  64'(exp_conflict));
      checkOutput({p, ".sticky"},    64'(sticky[m]),    64'(exp_sticky));
`ifdef BUS_ARB_CONFLICT_CNT_EN
      checkOutput({p, ".conflict_cnt"}, 64'(cnt[m]), 64'(exp_cnt));
`endif
    end
  endtask

  task automatic applyStimulus(input logic [NSRC-1:0] req, input logic h, input logic ec, input logic c);
    drv_req = req; hold = h; err_clr = ec; clr = c;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic randomData();
    for (int s = 0; s < NSRC; s++) src_data[s*WIDTH +: WIDTH] = $urandom;
  endtask

  initial begin
    logic [NSRC-1:0] r;
    int seq [4];
    seq = '{1, 2, 23, 1};
    src_data = '0; drv_req = '0; hold = 0; err_clr = 0; clr = 1;
    for (int m = 0; m < 2; m++) begin
      exp_bus[m] = '0; exp_valid[m] = 0; exp_grant[m] = 0; exp_idx[m] = 0; ptr[m] = 0;
    end
    exp_conflict = 0; exp_sticky = 0; exp_cnt = 0;
    #1;
    randomData();
    applyStimulus('0, 0, 0, 1);
    applyStimulus('0, 0, 0, 0);

    // Single request on source 4
    src_data[4*WIDTH +: WIDTH] = 32'hDEADBEEF;
    applyStimulus(24'h000010, 0, 0, 0);
    checkOutput("single.bus_out", 64'(bus_out[0]), 64'hDEADBEEF);
    checkOutput("single.grant_idx", 64'(grant_idx[0]), 64'd4);

    // Fixed-priority conflict pulse, sticky until err_clr
    applyStimulus(24'h800006, 0, 0, 0);
    checkOutput("prio.grant_idx", 64'(grant_idx[0]), 64'd1);
    checkOutput("prio.conflict", 64'(conflict[0]), 64'd1);
    applyStimulus('0, 0, 0, 0);
    checkOutput("prio.conflict_drop", 64'(conflict[0]), 64'd0);
    checkOutput("prio.sticky_held", 64'(sticky[0]), 64'd1);
    applyStimulus('0, 0, 1, 0);
    checkOutput("prio.sticky_clr", 64'(sticky[0]), 64'd0);

    // Round-robin rotation from a fresh pointer
    applyStimulus('0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(24'h800006, 0, 0, 0);
      checkOutput("rr.seq", 64'(grant_idx[1]), 64'(seq[i]));
    end

    // Hold freezes the output stage
    applyStimulus(24'h000008, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      randomData();
      applyStimulus(24'h000100, 1, 0, 0);
      checkOutput("hold.grant_idx", 64'(grant_idx[0]), 64'd3);
    end
    applyStimulus(24'h000100, 0, 0, 0);
    checkOutput("release.grant_idx", 64'(grant_idx[0]), 64'd8);

    // Long conflict run saturates the counter, then err_clr coincides with a conflict
    for (int i = 0; i < 300; i++) applyStimulus(24'h000003, 0, 0, 0);
`ifdef BUS_ARB_CONFLICT_CNT_EN
    checkOutput("cnt.saturate", 64'(cnt[0]), 64'd255);
`endif
    applyStimulus(24'h000003, 0, 1, 0);
    checkOutput("errclr_vs_conflict.sticky", 64'(sticky[0]), 64'd1);
`ifdef BUS_ARB_CONFLICT_CNT_EN
    checkOutput("errclr_vs_conflict.cnt", 64'(cnt[0]), 64'd1);
`endif

    // Reset overrides hold, err_clr and conflicting requests
    applyStimulus(24'h800006, 0, 0, 0);
    applyStimulus(24'h800006, 1, 1, 1);
    checkOutput("clr.valid", 64'(bus_valid[1]), 64'd0);
    applyStimulus(24'h800001, 0, 0, 0);
    checkOutput("clr.rr_from_zero", 64'(grant_idx[1]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      randomData();
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = NSRC'(1) << $urandom_range(0, NSRC - 1);
        2: r = NSRC'($urandom & $urandom & $urandom);
        default: r = NSRC'($urandom);
      endcase
      applyStimulus(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per source.
REQ-002 SHALL have parameter NSRC, default 24, number of bus sources (2..32).
REQ-003 SHALL have parameter MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port src_data  input  NSRC*WIDTH  source s occupies bits [s*WIDTH +: WIDTH].
REQ-007 SHALL have port drv_req  input  NSRC  per-source drive request (Rout-style strobes).
REQ-008 SHALL have port hold  input  1  stall; freezes output stage and arbitration state.
REQ-009 SHALL have port err_clr  input  1  clears conflict status.
REQ-010 SHALL have port bus_out  output  WIDTH  registered bus value.
REQ-011 SHALL have port bus_valid  output  1  bus_out carries granted data.
REQ-012 SHALL have port grant  output  NSRC  registered one-hot grant, or all zero.
REQ-013 SHALL have port grant_idx  output  $clog2(NSRC)  index of granted source, 0 when none.
REQ-014 SHALL have port conflict  output  1  registered one-cycle pulse: more than one drv_req bit set.
REQ-015 SHALL have port conflict_sticky  output  1  latched conflict flag.

Function
REQ-016 Latency SHALL be exactly one cycle: drv_req/src_data sampled at edge n appear on bus_out/grant/bus_valid after edge n.
REQ-017 With hold=0 and drv_req all zero, next cycle SHALL give bus_out=0, bus_valid=0, grant=0, grant_idx=0.
REQ-018 With exactly one request bit s set, next cycle SHALL give bus_out=src_data slice s, bus_valid=1, grant bit s only, grant_idx=s.
REQ-019 MODE=0 with multiple requests SHALL grant the lowest set index.
REQ-020 MODE=1 SHALL keep a pointer rr_ptr; the winner is the first set request at index >= rr_ptr, searching upward and wrapping from NSRC-1 to 0.
REQ-021 After each grant, rr_ptr SHALL become (winner+1) mod NSRC; with no grant it SHALL remain unchanged.
REQ-022 With multiple requests set and hold=0, conflict SHALL be 1 for the next cycle only, and conflict_sticky SHALL set.
REQ-023 err_clr=1 SHALL clear conflict_sticky on the next edge; if a conflict is detected in the same cycle, set SHALL win.
REQ-024 hold=1 SHALL keep bus_out, bus_valid, grant, grant_idx and rr_ptr unchanged, force conflict=0, and ignore drv_req (no conflict detection).
REQ-025 err_clr SHALL act regardless of hold.
REQ-026 Request bits at index >= NSRC SHALL NOT exist; grant SHALL never have more than one bit set.

Reset
REQ-027 clr=1 at an edge SHALL force bus_out=0, bus_valid=0, grant=0, grant_idx=0, conflict=0, conflict_sticky=0, rr_ptr=0, and conflict counter=0 if present.
REQ-028 clr SHALL override hold, err_clr and all requests in the same cycle; a transfer in flight is discarded.
REQ-029 The first edge with clr=0 SHALL arbitrate normally from rr_ptr=0.

Configuration
REQ-030 With macro BUS_ARB_CONFLICT_CNT_EN defined, the block SHALL add output conflict_cnt (8 bits), incremented on each detected conflict, saturating at 255, cleared by err_clr; with err_clr and a conflict in the same cycle it SHALL load 1.
REQ-031 Without BUS_ARB_CONFLICT_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=32, NSRC=24)
REQ-032 clr=1 then drv_req=0x000010, src_data[4]=0xDEADBEEF -> next cycle bus_out=0xDEADBEEF, grant=0x000010, grant_idx=4, bus_valid=1.
REQ-033 MODE=0, drv_req=0x800006 -> grant_idx=1, conflict pulses one cycle, conflict_sticky=1 until err_clr.
REQ-034 MODE=1, drv_req=0x800006 held for 4 cycles -> grant_idx sequence 1,2,23,1.
REQ-035 Grant on source 3, then hold=1 for 3 cycles with drv_req=0x000100 -> bus_out and grant_idx=3 frozen; release -> grant_idx=8.
REQ-036 BUS_ARB_CONFLICT_CNT_EN defined, 300 conflicting cycles -> conflict_cnt=255; err_clr with a conflict in the same cycle -> conflict_cnt=1, conflict_sticky=1.
REQ-037 clr=1 asserted mid-stream with hold=1 and conflicting requests -> all outputs 0 next cycle; MODE=1 next grant searches from index 0.
